fft_sched: RTL

FFT_SCHED -- requirements
Module: fft_sched

---
 rtl/fft_sched_if.sv | 33 +++
 rtl/fft_sched.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_sched_if.sv
// Bus bundle between the FFT scheduler and its sample memory / butterfly datapath.
interface fft_sched_if #(
    parameter int unsigned N_POINTS = 16
);
    localparam int unsigned L  = $clog2(N_POINTS);
    localparam int unsigned SW = (L > 1) ? $clog2(L) : 1;

    logic          start_i;
    logic          busy_o;
    logic          done_o;
    logic          rd_en_o;
    logic [L-1:0]  rd_addr_a_o;
    logic [L-1:0]  rd_addr_b_o;
    logic [L-2:0]  tw_addr_o;
    logic          wr_en_o;
    logic [L-1:0]  wr_addr_a_o;
    logic [L-1:0]  wr_addr_b_o;
    logic [SW-1:0] stage_o;

    // Scheduler side
    modport master (
        input  start_i,
        output busy_o, done_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o,
        output wr_en_o, wr_addr_a_o, wr_addr_b_o, stage_o
    );

    // Memory / datapath side
    modport slave (
        output start_i,
        input  busy_o, done_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o,
        input  wr_en_o, wr_addr_a_o, wr_addr_b_o, stage_o
    );
endinterface

// File: rtl/fft_sched.sv
// In-place radix-2 FFT address scheduler: issues one butterfly per cycle per
// stage, inserts a pipeline-drain gap between stages, and delays the read
// strobe/addresses to form the writeback strobe/addresses.
// Optional macro FFT_SCHED_BITREV_EN: bit-reverse stage-0 read addresses.
module fft_sched #(
    parameter int unsigned N_POINTS = 16,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned BFLY_LAT = 1
) (
    input logic         clk_i,
    input logic         rst_n,
    fft_sched_if.master bus
);
    localparam int unsigned L        = $clog2(N_POINTS);
    localparam int unsigned SW       = (L > 1) ? $clog2(L) : 1;
    localparam int unsigned KW       = L - 1;
    localparam int unsigned PIPE_LAT = RD_LAT + BFLY_LAT;
    localparam int unsigned GW       = $clog2(PIPE_LAT + 1);

    localparam logic [KW-1:0] K_LAST = KW'(N_POINTS / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(L - 1);
    localparam logic [GW-1:0] G_LAST = GW'(PIPE_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [SW-1:0] s_q, s_d;
    logic [GW-1:0] g_q, g_d;
    logic          issue_c, busy_c, done_c;

    logic [L-1:0]  h_c, p_c, a_c, b_c, a_rd_c, b_rd_c;
    logic [L-2:0]  tw_c;

    logic          rd_en_q, busy_q, done_q;
    logic [L-1:0]  rd_a_q, rd_b_q, nat_a_q, nat_b_q;
    logic [L-2:0]  tw_q;
    logic [SW-1:0] stage_q;

    logic          pipe_en_q [PIPE_LAT];
    logic [L-1:0]  pipe_a_q  [PIPE_LAT];
    logic [L-1:0]  pipe_b_q  [PIPE_LAT];

    // State and counter registers
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            s_q     <= '0;
            g_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            s_q     <= s_d;
            g_q     <= g_d;
        end
    end

    // Next-state, counter updates and per-cycle decode
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        g_d     = g_q;
        issue_c = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = RUN;
                    k_d     = '0;
                    s_d     = '0;
                    g_d     = '0;
                end
            end
            RUN: begin
                issue_c = 1'b1;
                busy_c  = 1'b1;
                if (k_q == K_LAST) begin
                    state_d = GAP;
                    g_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            GAP: begin
                busy_c = 1'b1;
                if (g_q == G_LAST) begin
                    k_d = '0;
                    if (s_q == S_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        s_d     = s_q + SW'(1);
                    end
                end else begin
                    g_d = g_q + GW'(1);
                end
            end
            DONE: begin
                done_c = 1'b1;
                if (bus.start_i) begin
                    state_d = RUN;
                    k_d     = '0;
                    s_d     = '0;
                    g_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Natural-order butterfly addresses and twiddle index for (s, k)
    always_comb begin
        h_c  = L'(1) << s_q;
        p_c  = L'(k_q) & (h_c - L'(1));
        a_c  = (((L'(k_q) >> s_q) << s_q) << 1) | p_c;
        b_c  = a_c + h_c;
        tw_c = (L-1)'(p_c << (S_LAST - s_q));
    end

`ifdef FFT_SCHED_BITREV_EN
    logic [L-1:0] a_rev_c, b_rev_c;

    // Stage-0 reads fetch from bit-reversed locations so input can be stored naturally
    always_comb begin
        a_rev_c = '0;
        b_rev_c = '0;
        for (int i = 0; i < int'(L); i++) begin
            a_rev_c[i] = a_c[int'(L) - 1 - i];
            b_rev_c[i] = b_c[int'(L) - 1 - i];
        end
        a_rd_c = (s_q == '0) ? a_rev_c : a_c;
        b_rd_c = (s_q == '0) ? b_rev_c : b_c;
    end
`else
    assign a_rd_c = a_c;
    assign b_rd_c = b_c;
`endif

    // Registered issue-side outputs
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            nat_a_q <= '0;
            nat_b_q <= '0;
            tw_q    <= '0;
            stage_q <= '0;
        end else begin
            rd_en_q <= issue_c;
            busy_q  <= busy_c;
            done_q  <= done_c;
            rd_a_q  <= issue_c ? a_rd_c : '0;
            rd_b_q  <= issue_c ? b_rd_c : '0;
            nat_a_q <= issue_c ? a_c : '0;
            nat_b_q <= issue_c ? b_c : '0;
            tw_q    <= issue_c ? tw_c : '0;
            stage_q <= s_q;
        end
    end

    // Writeback delay line: read strobe and natural addresses delayed by PIPE_LAT
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(PIPE_LAT); i++) begin
                pipe_en_q[i] <= 1'b0;
                pipe_a_q[i]  <= '0;
                pipe_b_q[i]  <= '0;
            end
        end else begin
            pipe_en_q[0] <= rd_en_q;
            pipe_a_q[0]  <= nat_a_q;
            pipe_b_q[0]  <= nat_b_q;
            for (int i = 1; i < int'(PIPE_LAT); i++) begin
                pipe_en_q[i] <= pipe_en_q[i-1];
                pipe_a_q[i]  <= pipe_a_q[i-1];
                pipe_b_q[i]  <= pipe_b_q[i-1];
            end
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.rd_en_o     = rd_en_q;
    assign bus.rd_addr_a_o = rd_a_q;
    assign bus.rd_addr_b_o = rd_b_q;
    assign bus.tw_addr_o   = tw_q;
    assign bus.stage_o     = stage_q;
    assign bus.wr_en_o     = pipe_en_q[PIPE_LAT-1];
    assign bus.wr_addr_a_o = pipe_a_q[PIPE_LAT-1];
    assign bus.wr_addr_b_o = pipe_b_q[PIPE_LAT-1];

endmodule
